// File: rtl/ebr_pingpong_ctrl.sv
// ---------------------------------------------------------------------------
// ebr_pingpong_ctrl
//
// Ping-pong controller for two external iCE40 dual-port EBR banks. Incoming
// pixels fill one bank while the other bank drains to a valid/ready output
// stream. A bank holds 8 lines of 2^LINE_WIDTH_LOG2 pixels. The controller
// owns every EBR address and enable pin. Read data returns one cycle after
// the address is issued and is caught in a 2-entry skid FIFO, so output
// backpressure never loses a word that is already in flight.
//
// Build option:
//   EBR_PP_BLOCK_ORDER_EN  When defined, a bank drains in 8x8 block order:
//                          blocks run left to right, and rows run top to
//                          bottom within each block. When undefined, a bank
//                          drains in raster order.
//
// Ports:
//   clk        single clock; also drives the EBR wclk and rclk
//   rst        synchronous, active-high reset
//   wr_valid   input pixel valid
//   wr_data    input pixel
//   wr_ready   pixel accepted this cycle (combinational)
//   out_valid  out_data valid
//   out_data   drained pixel
//   out_ready  consumer accepts out_data
//   ebr_din    write data shared by both banks (= wr_data)
//   ebr_waddr  write address shared by both banks
//   ebr_we     per-bank write enable
//   ebr_raddr  read address shared by both banks
//   ebr_dout0  bank 0 registered read data
//   ebr_dout1  bank 1 registered read data
//   bank_full  per-bank FULL|DRAINING status
// ---------------------------------------------------------------------------
module ebr_pingpong_ctrl #(
    parameter int DATA_WIDTH      = 8,
    parameter int LINE_WIDTH_LOG2 = 6
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       wr_valid,
    input  logic [DATA_WIDTH-1:0]      wr_data,
    output logic                       wr_ready,
    output logic                       out_valid,
    output logic [DATA_WIDTH-1:0]      out_data,
    input  logic                       out_ready,
    output logic [DATA_WIDTH-1:0]      ebr_din,
    output logic [LINE_WIDTH_LOG2+2:0] ebr_waddr,
    output logic [1:0]                 ebr_we,
    output logic [LINE_WIDTH_LOG2+2:0] ebr_raddr,
    input  logic [DATA_WIDTH-1:0]      ebr_dout0,
    input  logic [DATA_WIDTH-1:0]      ebr_dout1,
    output logic [1:0]                 bank_full
);

    localparam int ADDR_WIDTH = LINE_WIDTH_LOG2 + 3;

    // Bit 1 of the encoding is set exactly for FULL and DRAINING. The writer
    // and reader therefore only have to test that one bit.
    localparam logic [1:0] ST_EMPTY    = 2'd0;
    localparam logic [1:0] ST_FILLING  = 2'd1;
    localparam logic [1:0] ST_FULL     = 2'd2;
    localparam logic [1:0] ST_DRAINING = 2'd3;

    logic                  wbank_q, wbank_d;
    logic                  rbank_q, rbank_d;
    logic [ADDR_WIDTH-1:0] wcnt_q, wcnt_d;
    logic [ADDR_WIDTH-1:0] rcnt_q, rcnt_d;
    logic                  inflight_q, inflight_d;
    logic                  inflight_tag_q, inflight_tag_d;
    logic [DATA_WIDTH-1:0] skid_mem_q [2];
    logic                  skid_wptr_q, skid_wptr_d;
    logic                  skid_rptr_q, skid_rptr_d;
    logic [1:0]            skid_cnt_q, skid_cnt_d;

    logic [3:0]            bank_state;
    logic [1:0]            wr_state, rd_state;
    logic                  wr_fire, wr_last;
    logic                  rd_issue, rd_last, rd_room;
    logic                  skid_push, skid_pop;
    logic [1:0]            occ;
    logic [DATA_WIDTH-1:0] ret_data;

    // Per-bank state machine: a state register plus a next-state function.
    // The writer and the reader never touch the same bank in one cycle,
    // because they require disjoint states. Their updates therefore compose
    // without conflict.
    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_bank
            logic [1:0] state_q, state_d;

            always_ff @(posedge clk) begin
                if (rst) begin
                    state_q <= ST_EMPTY;
                end else begin
                    state_q <= state_d;
                end
            end

            always_comb begin
                state_d = state_q;
                if (wr_fire && (wbank_q == 1'(gi))) begin
                    state_d = wr_last ? ST_FULL : ST_FILLING;
                end
                if (rd_issue && (rbank_q == 1'(gi))) begin
                    state_d = rd_last ? ST_EMPTY : ST_DRAINING;
                end
            end

            assign bank_state[2*gi +: 2] = state_q;
            assign bank_full[gi]         = state_q[1];
        end
    endgenerate

    assign wr_state = wbank_q ? bank_state[3:2] : bank_state[1:0];
    assign rd_state = rbank_q ? bank_state[3:2] : bank_state[1:0];
    assign wr_last  = (wcnt_q == '1);
    assign rd_last  = (rcnt_q == '1);

    // Output and datapath decode
    always_comb begin
        wr_ready  = ~wr_state[1];
        wr_fire   = wr_valid & wr_ready;
        ebr_we    = 2'b00;
        if (wr_fire) begin
            ebr_we[wbank_q] = 1'b1;
        end
        ebr_waddr = wcnt_q;
        ebr_din   = wr_data;

        out_valid = (skid_cnt_q != 2'd0);
        out_data  = skid_mem_q[skid_rptr_q];
        skid_pop  = out_valid & out_ready;
        skid_push = inflight_q;
        ret_data  = inflight_tag_q ? ebr_dout1 : ebr_dout0;

        // Words already committed to the skid. A pop in this same cycle frees
        // one slot in time for the word issued now, which keeps the drain at
        // one word per cycle when the consumer is always ready.
        occ       = skid_cnt_q + {1'b0, inflight_q};
        rd_room   = (occ < 2'd2) | ((occ == 2'd2) & skid_pop);
        rd_issue  = rd_state[1] & rd_room;

`ifdef EBR_PP_BLOCK_ORDER_EN
        // rcnt = {block, row, col} -> address = {row, block, col}
        ebr_raddr = {rcnt_q[5:3], rcnt_q[ADDR_WIDTH-1:6], rcnt_q[2:0]};
`else
        ebr_raddr = rcnt_q;
`endif
    end

    // Next-state values for the pointers, the counters and the skid FIFO
    always_comb begin
        wcnt_d         = wr_fire ? wcnt_q + ADDR_WIDTH'(1) : wcnt_q;
        wbank_d        = wbank_q ^ (wr_fire & wr_last);
        rcnt_d         = rd_issue ? rcnt_q + ADDR_WIDTH'(1) : rcnt_q;
        rbank_d        = rbank_q ^ (rd_issue & rd_last);
        inflight_d     = rd_issue;
        inflight_tag_d = rbank_q;
        skid_wptr_d    = skid_wptr_q ^ skid_push;
        skid_rptr_d    = skid_rptr_q ^ skid_pop;
        case ({skid_push, skid_pop})
            2'b10:   skid_cnt_d = skid_cnt_q + 2'd1;
            2'b01:   skid_cnt_d = skid_cnt_q - 2'd1;
            default: skid_cnt_d = skid_cnt_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wbank_q        <= 1'b0;
            rbank_q        <= 1'b0;
            wcnt_q         <= '0;
            rcnt_q         <= '0;
            inflight_q     <= 1'b0;
            inflight_tag_q <= 1'b0;
            skid_wptr_q    <= 1'b0;
            skid_rptr_q    <= 1'b0;
            skid_cnt_q     <= 2'd0;
        end else begin
            wbank_q        <= wbank_d;
            rbank_q        <= rbank_d;
            wcnt_q         <= wcnt_d;
            rcnt_q         <= rcnt_d;
            inflight_q     <= inflight_d;
            inflight_tag_q <= inflight_tag_d;
            skid_wptr_q    <= skid_wptr_d;
            skid_rptr_q    <= skid_rptr_d;
            skid_cnt_q     <= skid_cnt_d;
        end
    end

    // Skid storage needs no reset; the occupancy count alone decides validity.
    always_ff @(posedge clk) begin
        if (skid_push) begin
            skid_mem_q[skid_wptr_q] <= ret_data;
        end
    end

endmodule

// File: tb/tb_ebr_pingpong_ctrl.sv
`timescale 1ns/1ps
module tb_ebr_pingpong_ctrl;

    localparam int DW    = 8;
    localparam int LW    = 6;
    localparam int AW    = LW + 3;
    localparam int DEPTH = 1 << AW;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          wr_valid = 1'b0;
    logic [DW-1:0] wr_data = '0;
    logic          wr_ready;
    logic          out_valid;
    logic [DW-1:0] out_data;
    logic          out_ready = 1'b1;
    logic [DW-1:0] ebr_din;
    logic [AW-1:0] ebr_waddr;
    logic [1:0]    ebr_we;
    logic [AW-1:0] ebr_raddr;
    logic [DW-1:0] ebr_dout0 = '0;
    logic [DW-1:0] ebr_dout1 = '0;
    logic [1:0]    bank_full;

    ebr_pingpong_ctrl #(.DATA_WIDTH(DW), .LINE_WIDTH_LOG2(LW)) dut (
        .clk       (clk),
        .rst       (rst),
        .wr_valid  (wr_valid),
        .wr_data   (wr_data),
        .wr_ready  (wr_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_ready (out_ready),
        .ebr_din   (ebr_din),
        .ebr_waddr (ebr_waddr),
        .ebr_we    (ebr_we),
        .ebr_raddr (ebr_raddr),
        .ebr_dout0 (ebr_dout0),
        .ebr_dout1 (ebr_dout1),
        .bank_full (bank_full)
    );

    initial forever #5 clk = ~clk;

    // Two EBR banks with registered read ports
    logic [DW-1:0] mem0 [DEPTH];
    logic [DW-1:0] mem1 [DEPTH];
    always @(posedge clk) begin
        if (ebr_we[0]) mem0[ebr_waddr] <= ebr_din;
        if (ebr_we[1]) mem1[ebr_waddr] <= ebr_din;
        ebr_dout0 <= mem0[ebr_raddr];
        ebr_dout1 <= mem1[ebr_raddr];
    end

    int            vectors = 0;
    int            miscompares = 0;
    int            cyc = 0;
    int            last_acc_cyc = 0;
    int            tb_wcnt = 0;
    logic          tb_wbank = 1'b0;
    int            we0 = 0;
    int            we1 = 0;
    int            out_n = 0;
    bit            rand_rdy = 1'b0;
    logic [DW-1:0] cap [DEPTH];
    logic [DW-1:0] exp_q [$];
    logic [DW-1:0] exp_word;

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    initial forever begin
        @(posedge clk);
        #1;
        if (rand_rdy) out_ready = 1'($urandom_range(0, 1));
    end

    always @(negedge clk) begin
        if (!rst) begin
            we0 = we0 + (ebr_we[0] ? 1 : 0);
            we1 = we1 + (ebr_we[1] ? 1 : 0);
        end
    end

    // Drain order of bank word k: raster, or {b,r,c} -> {r,b,c} in block mode.
    function automatic int drain_addr(input int k);
`ifdef EBR_PP_BLOCK_ORDER_EN
        return ((k >> 3) & 7) * 64 + ((k >> 6) & 7) * 8 + (k & 7);
`else
        return k;
`endif
    endfunction

    // Scoreboard monitor: pop the expected word for every output handshake.
    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            out_n++;
            vectors++;
            if (exp_q.size() == 0) begin
                miscompares++;
                $display("FAIL out_unexpected #%0d: got %02h, required no output", out_n, out_data);
            end else begin
                exp_word = exp_q.pop_front();
                if (out_data !== exp_word) begin
                    miscompares++;
                    $display("FAIL out_data #%0d: got %02h, required %02h", out_n, out_data, exp_word);
                end else begin
                    $display("out #%0d data=%02h ok", out_n, out_data);
                end
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv, input bit show);
        vectors++;
        if (act !== expv) begin
            miscompares++;
            $display("FAIL %s: got %0h, required %0h", name, act, expv);
        end else if (show) begin
            $display("check %s = %0h ok", name, act);
        end
    endtask

    // Present one word and hold it until accepted; check the EBR write pins.
    task automatic write_word(input logic [DW-1:0] d);
        bit acc = 1'b0;
        int n = 0;
        wr_valid = 1'b1;
        wr_data  = d;
        while (!acc && n < 5000) begin
            @(negedge clk);
            if (wr_ready) begin
                acc = 1'b1;
                chk("ebr_we", 32'(ebr_we), tb_wbank ? 32'd2 : 32'd1, 1'b0);
                chk("ebr_waddr", 32'(ebr_waddr), tb_wcnt, 1'b0);
                chk("ebr_din", 32'(ebr_din), 32'(d), 1'b0);
                last_acc_cyc = cyc;
                cap[tb_wcnt] = d;
                if (tb_wcnt == DEPTH - 1) begin
                    for (int k = 0; k < DEPTH; k++) exp_q.push_back(cap[drain_addr(k)]);
                    tb_wcnt  = 0;
                    tb_wbank = ~tb_wbank;
                end else begin
                    tb_wcnt++;
                end
            end else begin
                chk("stall_needs_both_full", 32'(bank_full), 32'd3, 1'b0);
                n++;
            end
            @(posedge clk);
            #1;
        end
        if (!acc) chk("write_timeout", 32'd1, 32'd0, 1'b1);
    endtask

    task automatic do_reset();
        rst      = 1'b1;
        wr_valid = 1'b0;
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        rst      = 1'b0;
        exp_q.delete();
        tb_wcnt  = 0;
        tb_wbank = 1'b0;
    endtask

    task automatic wait_drain();
        int n = 0;
        int extra = 0;
        while (exp_q.size() != 0 && n < 20000) begin
            @(negedge clk);
            n++;
        end
        chk("drain_left", exp_q.size(), 32'd0, 1'b1);
        repeat (6) begin
            @(negedge clk);
            if (out_valid) extra++;
        end
        chk("idle_out_valid", extra, 32'd0, 1'b1);
        @(posedge clk);
        #1;
    endtask

    initial begin
        int lat;
        int n;
        int seen;
        logic [AW-1:0] prev_raddr;

        // Reset state
        do_reset();
        @(negedge clk);
        chk("rst_out_valid", 32'(out_valid), 32'd0, 1'b1);
        chk("rst_bank_full", 32'(bank_full), 32'd0, 1'b1);
        chk("rst_ebr_we", 32'(ebr_we), 32'd0, 1'b1);
        chk("rst_wr_ready", 32'(wr_ready), 32'd1, 1'b1);
        @(posedge clk);
        #1;

        // Fill one bank with i[7:0], then check drain order and latency
        we0 = 0;
        we1 = 0;
        for (int i = 0; i < DEPTH; i++) write_word(8'(i));
        wr_valid = 1'b0;
        lat = -1;
        for (int j = 0; j < 10; j++) begin
            @(negedge clk);
            if (out_valid) begin
                lat = cyc - last_acc_cyc;
                break;
            end
        end
        chk("first_out_latency", lat, 32'd3, 1'b1);
        wait_drain();
        chk("bank0_we_pulses", we0, 32'd512, 1'b1);
        chk("bank1_we_pulses", we1, 32'd0, 1'b1);

        // Last write into bank1 lands in the same cycle as bank0's last read issue
        do_reset();
        out_ready = 1'b1;
        for (int i = 0; i < 2 * DEPTH; i++) write_word(8'(i * 3));
        wr_valid = 1'b0;
        @(negedge clk);
        chk("swap_bank_full", 32'(bank_full), 32'd2, 1'b1);
        chk("swap_wr_ready", 32'(wr_ready), 32'd1, 1'b1);
        @(posedge clk);
        #1;
        for (int i = 0; i < DEPTH; i++) write_word(8'(i + 17));
        wr_valid = 1'b0;
        wait_drain();

        // Continuous stream with a randomly stalling consumer
        do_reset();
        rand_rdy = 1'b1;
        for (int i = 0; i < 4 * DEPTH; i++) write_word(8'(i * 7 + 3));
        wr_valid = 1'b0;
        wait_drain();
        rand_rdy = 1'b0;
        @(posedge clk);
        #1;
        out_ready = 1'b1;

        // Consumer blocked: both banks fill, then release frees bank0
        do_reset();
        out_ready = 1'b0;
        for (int i = 0; i < 2 * DEPTH; i++) write_word(8'(i ^ 32'h5A));
        wr_valid = 1'b0;
        @(negedge clk);
        chk("blocked_wr_ready", 32'(wr_ready), 32'd0, 1'b1);
        chk("blocked_bank_full", 32'(bank_full), 32'd3, 1'b1);
        @(posedge clk);
        #1;
        out_ready  = 1'b1;
        prev_raddr = ebr_raddr;
        n = 0;
        while (n < 2000) begin
            @(negedge clk);
            if (wr_ready) break;
            prev_raddr = ebr_raddr;
            n++;
        end
        chk("release_wr_ready", 32'(wr_ready), 32'd1, 1'b1);
        chk("raddr_before_release", 32'(prev_raddr), 32'd511, 1'b1);
        chk("release_bank_full", 32'(bank_full), 32'd2, 1'b1);
        @(posedge clk);
        #1;
        wait_drain();

        // Reset in the middle of a drain while the other bank fills
        do_reset();
        out_ready = 1'b1;
        for (int i = 0; i < DEPTH + 100; i++) write_word(8'(i));
        do_reset();
        @(negedge clk);
        chk("midrst_out_valid", 32'(out_valid), 32'd0, 1'b1);
        chk("midrst_bank_full", 32'(bank_full), 32'd0, 1'b1);
        chk("midrst_wr_ready", 32'(wr_ready), 32'd1, 1'b1);
        seen = 0;
        repeat (10) begin
            @(negedge clk);
            if (out_valid) seen++;
        end
        chk("midrst_no_output", seen, 32'd0, 1'b1);
        @(posedge clk);
        #1;
        for (int i = 0; i < DEPTH; i++) write_word(8'(i + 100));
        wr_valid = 1'b0;
        wait_drain();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not complete, required completion");
        $fatal(1, "watchdog");
    end

endmodule
